// File: rtl/fac_digit_uart_emitter_if.sv
// Caller-facing bundle for fac_digit_uart_emitter: value/delimiter inputs and UART/result outputs.
interface fac_digit_uart_emitter_if;
  logic [21:0] n;
  logic [7:0]  delim1byte;
  logic [7:0]  delim2byte;
  logic        outchan;
  logic        result_ready;
  logic [3:0]  result;

  modport master (
    output n, delim1byte, delim2byte,
    input  outchan, result_ready, result
  );

  modport slave (
    input  n, delim1byte, delim2byte,
    output outchan, result_ready, result
  );
endinterface

// File: rtl/fac_digit_uart_emitter.sv
// Prints a 22-bit value in the factorial number system as ASCII over an 8N1 UART, then two delimiters.
// Optional FACDIG_LZ_SUPPRESS_EN: suppress leading zero digits (otherwise all 10 positions are sent).
module fac_digit_uart_emitter #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input logic                      clk,
  input logic                      start,
  fac_digit_uart_emitter_if.slave  bus
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  // Without suppression every position counts as significant from the outset.
`ifdef FACDIG_LZ_SUPPRESS_EN
  localparam logic SEEN_INIT = 1'b0;
`else
  localparam logic SEEN_INIT = 1'b1;
`endif

  typedef enum logic [2:0] {
    S_LOAD, S_DIV, S_EMIT, S_SEND, S_NEXT, S_DELIM1, S_DELIM2, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    TX_DIGIT, TX_DELIM1, TX_DELIM2
  } tx_kind_t;

  state_t      state_q, state_d;
  tx_kind_t    tx_kind_q;
  logic [21:0] n_q;
  logic [7:0]  d1_q, d2_q;
  logic [21:0] r_q;
  logic [3:0]  k_q, d_q;
  logic        seen_q;
  logic [3:0]  result_q;
  logic [9:0]  shreg_q;
  logic [BW-1:0] baud_q;
  logic [3:0]  bit_q;

  logic [21:0] fac_k;
  logic        div_ge;
  logic        emit_digit;
  logic        baud_last;
  logic        frame_end;
  logic [7:0]  ascii;

  function automatic logic [21:0] fac(input logic [3:0] k);
    case (k)
      4'd1:    return 22'd1;
      4'd2:    return 22'd2;
      4'd3:    return 22'd6;
      4'd4:    return 22'd24;
      4'd5:    return 22'd120;
      4'd6:    return 22'd720;
      4'd7:    return 22'd5040;
      4'd8:    return 22'd40320;
      4'd9:    return 22'd362880;
      4'd10:   return 22'd3628800;
      default: return 22'd1;
    endcase
  endfunction

  always_comb begin
    fac_k      = fac(k_q);
    div_ge     = (r_q >= fac_k);
    emit_digit = (d_q != 4'd0) || seen_q || (k_q == 4'd1);
    baud_last  = (baud_q == BAUD_LAST);
    frame_end  = baud_last && (bit_q == 4'd9);
    ascii      = (d_q <= 4'd9) ? (8'h30 + {4'h0, d_q}) : (8'h37 + {4'h0, d_q});
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:   state_d = S_DIV;
      S_DIV:    if (!div_ge) state_d = S_EMIT;
      S_EMIT:   state_d = emit_digit ? S_SEND : S_NEXT;
      S_SEND: begin
        if (frame_end) begin
          case (tx_kind_q)
            TX_DIGIT:  state_d = S_NEXT;
            TX_DELIM1: state_d = S_DELIM2;
            default:   state_d = S_DONE;
          endcase
        end
      end
      S_NEXT:   state_d = (k_q > 4'd1) ? S_DIV : S_DELIM1;
      S_DELIM1: state_d = S_SEND;
      S_DELIM2: state_d = S_SEND;
      S_DONE:   state_d = S_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (start) begin
      state_q   <= S_LOAD;
      n_q       <= bus.n;
      d1_q      <= bus.delim1byte;
      d2_q      <= bus.delim2byte;
      r_q       <= '0;
      k_q       <= '0;
      d_q       <= '0;
      seen_q    <= 1'b0;
      result_q  <= '0;
      shreg_q   <= '1;
      baud_q    <= '0;
      bit_q     <= '0;
      tx_kind_q <= TX_DIGIT;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_LOAD: begin
          r_q    <= n_q;
          k_q    <= 4'd10;
          d_q    <= '0;
          seen_q <= SEEN_INIT;
        end
        S_DIV: begin
          if (div_ge) begin
            r_q <= r_q - fac_k;
            d_q <= d_q + 4'd1;
          end
        end
        S_EMIT: begin
          if (emit_digit) begin
            shreg_q   <= {1'b1, ascii, 1'b0};
            seen_q    <= 1'b1;
            result_q  <= result_q + 4'd1;
            tx_kind_q <= TX_DIGIT;
            baud_q    <= '0;
            bit_q     <= '0;
          end
        end
        S_SEND: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= bit_q + 4'd1;
            shreg_q <= {1'b1, shreg_q[9:1]};
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_NEXT: begin
          if (k_q > 4'd1) begin
            k_q <= k_q - 4'd1;
            d_q <= '0;
          end
        end
        S_DELIM1: begin
          shreg_q   <= {1'b1, d1_q, 1'b0};
          tx_kind_q <= TX_DELIM1;
          baud_q    <= '0;
          bit_q     <= '0;
        end
        S_DELIM2: begin
          shreg_q   <= {1'b1, d2_q, 1'b0};
          tx_kind_q <= TX_DELIM2;
          baud_q    <= '0;
          bit_q     <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.outchan      = (state_q != S_SEND) | shreg_q[0];
  assign bus.result_ready = (state_q == S_DONE) & ~start;
  assign bus.result       = result_q;

endmodule
